// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard and forwarding controller for an in-order RISC-V pipe.
//               Tracks in-flight destinations (EX..WB), detects RAW hazards at
//               ID, raises load-use stalls and branch flushes, and selects
//               forwarded EX operands. Keeps saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
  parameter  int XLEN       = 32,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_READY = 2,
  parameter  int CNT_W      = 16,
  localparam int FSW        = $clog2(DEPTH)
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd,
  input  logic                  id_rf_we,
  input  logic                  id_is_load,
  input  logic                  ex_br_taken,
  input  logic [XLEN-1:0]       ex_rD1,
  input  logic [XLEN-1:0]       ex_rD2,
  input  logic [DEPTH*XLEN-1:0] stage_wdata,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [FSW-1:0]        ex_fwd_sel_a,
  output logic [FSW-1:0]        ex_fwd_sel_b,
  output logic [XLEN-1:0]       ex_opa,
  output logic [XLEN-1:0]       ex_opb,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        sb_d [DEPTH];
  logic [FSW-1:0]   fwd_sel_a_q, fwd_sel_a_d;
  logic [FSW-1:0]   fwd_sel_b_q, fwd_sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             lu_a, lu_b;
  logic [FSW-1:0]   fsel_a, fsel_b;
  logic             load_use, stall, flush;

  // Slice 0 is the EX stage itself; its operands come from ex_rD1/ex_rD2.
  logic unused_slice0;
  assign unused_slice0 = ^stage_wdata[XLEN-1:0];

  // Find the youngest producer per source; scanning old->young lets the lowest k overwrite.
  always_comb begin
    lu_a   = 1'b0;
    lu_b   = 1'b0;
    fsel_a = '0;
    fsel_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_q[k].valid && sb_q[k].we && (sb_q[k].rd != 5'd0)) begin
        if (id_valid && id_rs1_used && (sb_q[k].rd == id_rs1)) begin
          lu_a   = sb_q[k].is_load && ((k + 1) < LOAD_READY);
          // WB is write-through, so a WB-only match reads the register file.
          fsel_a = (k < DEPTH - 1) ? FSW'(k + 1) : '0;
        end
        if (id_valid && id_rs2_used && (sb_q[k].rd == id_rs2)) begin
          lu_b   = sb_q[k].is_load && ((k + 1) < LOAD_READY);
          fsel_b = (k < DEPTH - 1) ? FSW'(k + 1) : '0;
        end
      end
    end
  end

  // Pipeline control: a taken branch squashes ID and overrides any load-use stall.
  always_comb begin
    load_use     = lu_a | lu_b;
    flush        = ex_br_taken;
    stall        = load_use & ~flush;
    pc_stall     = stall;
    if_id_stall  = stall;
    id_ex_bubble = stall | flush;
    if_id_flush  = flush;
  end

  // Next-state: shift scoreboard, capture forwarding selects, bump saturating counters.
  always_comb begin
    sb_d[0] = '0;
    if (!(stall || flush)) begin
      sb_d[0].valid   = id_valid;
      sb_d[0].rd      = id_rd;
      sb_d[0].we      = id_rf_we;
      sb_d[0].is_load = id_is_load;
    end
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    fwd_sel_a_d = (stall || flush) ? '0 : fsel_a;
    fwd_sel_b_d = (stall || flush) ? '0 : fsel_b;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      fwd_sel_a_q <= '0;
      fwd_sel_b_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
      fwd_sel_a_q <= fwd_sel_a_d;
      fwd_sel_b_q <= fwd_sel_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // EX operand mux: select 0 keeps the register-file value.
  always_comb begin
    ex_opa = ex_rD1;
    ex_opb = ex_rD2;
    for (int k = 1; k < DEPTH; k++) begin
      if (fwd_sel_a_q == FSW'(k)) ex_opa = stage_wdata[k*XLEN +: XLEN];
      if (fwd_sel_b_q == FSW'(k)) ex_opb = stage_wdata[k*XLEN +: XLEN];
    end
  end

  assign ex_fwd_sel_a = fwd_sel_a_q;
  assign ex_fwd_sel_b = fwd_sel_b_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Directed self-checking bench for pipe_hazard_unit (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 3;
  localparam int FSW   = $clog2(DEPTH);
  localparam int CNT_W = 16;

  logic                  cpu_clk = 1'b0;
  logic                  cpu_rst;
  logic                  id_valid, id_rs1_used, id_rs2_used, id_rf_we, id_is_load;
  logic [4:0]            id_rs1, id_rs2, id_rd;
  logic                  ex_br_taken;
  logic [XLEN-1:0]       ex_rD1, ex_rD2;
  logic [DEPTH*XLEN-1:0] stage_wdata;
  logic                  pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
  logic [FSW-1:0]        ex_fwd_sel_a, ex_fwd_sel_b;
  logic [XLEN-1:0]       ex_opa, ex_opb;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_READY(2), .CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken), .ex_rD1(ex_rD1), .ex_rD2(ex_rD2),
    .stage_wdata(stage_wdata),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .ex_fwd_sel_a(ex_fwd_sel_a), .ex_fwd_sel_b(ex_fwd_sel_b),
    .ex_opa(ex_opa), .ex_opb(ex_opb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the instruction currently sitting in ID.
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rf_we = we; id_is_load = ld;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic ctrl(input string tag, input logic s, input logic b, input logic f);
    chk({tag, ".pc_stall"},     pc_stall,     s);
    chk({tag, ".if_id_stall"},  if_id_stall,  s);
    chk({tag, ".id_ex_bubble"}, id_ex_bubble, b);
    chk({tag, ".if_id_flush"},  if_id_flush,  f);
  endtask

  initial begin
    ex_rD1      = 32'h0000_1111;
    ex_rD2      = 32'h0000_2222;
    stage_wdata = {32'h0000_00BB, 32'h0000_00AA, 32'h0000_0011};
    ex_br_taken = 1'b0;
    cpu_rst     = 1'b0;
    // add x5,x1,x2 held in ID through reset
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    tick(); tick();
    @(negedge cpu_clk);
    ctrl("reset", 0, 0, 0);
    chk("reset.sel_a", ex_fwd_sel_a, 0);
    chk("reset.sel_b", ex_fwd_sel_b, 0);
    chk("reset.opa", ex_opa, 32'h0000_1111);
    chk("reset.opb", ex_opb, 32'h0000_2222);
    chk("reset.stall_cnt", stall_cnt, 0);
    chk("reset.flush_cnt", flush_cnt, 0);
    tick();
    cpu_rst = 1'b1;
    tick();                                    // add x5 enters EX
    // sub x6,x5,x1 : EX->EX forward
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    @(negedge cpu_clk);
    ctrl("fwd1", 0, 0, 0);
    tick();
    @(negedge cpu_clk);
    chk("fwd1.sel_a", ex_fwd_sel_a, 1);
    chk("fwd1.sel_b", ex_fwd_sel_b, 0);
    chk("fwd1.opa", ex_opa, 32'h0000_00AA);
    chk("fwd1.opb", ex_opb, 32'h0000_2222);
    // lw x6,0(x2)
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1);
    tick();
    // add x7,x6,x1 : load-use, one stall cycle
    set_id(1, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0);
    @(negedge cpu_clk);
    ctrl("lu.stall", 1, 1, 0);
    tick();
    @(negedge cpu_clk);
    ctrl("lu.release", 0, 0, 0);
    chk("lu.bubble_sel_a", ex_fwd_sel_a, 0);
    chk("lu.stall_cnt", stall_cnt, 1);
    tick();
    @(negedge cpu_clk);
    chk("lu.sel_a", ex_fwd_sel_a, 2);
    chk("lu.opa", ex_opa, 32'h0000_00BB);
    // addi x5,x0,1 ; nop ; or x8,x5,x5
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd5, 1, 5'd8, 1, 0);
    @(negedge cpu_clk);
    ctrl("mem_fwd", 0, 0, 0);
    tick();
    @(negedge cpu_clk);
    chk("mem_fwd.sel_a", ex_fwd_sel_a, 2);
    chk("mem_fwd.sel_b", ex_fwd_sel_b, 2);
    chk("mem_fwd.opb", ex_opb, 32'h0000_00BB);
    // addi x0,x1,1 then add x9,x0,x0 : x0 never forwards
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0);
    @(negedge cpu_clk);
    ctrl("x0", 0, 0, 0);
    tick();
    @(negedge cpu_clk);
    chk("x0.sel_a", ex_fwd_sel_a, 0);
    chk("x0.sel_b", ex_fwd_sel_b, 0);
    // add x5 ; addi x5,x5,1 ; add x10,x5,x0 : youngest x5 wins
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 1, 5'd10, 1, 0);
    tick();
    @(negedge cpu_clk);
    chk("youngest.sel_a", ex_fwd_sel_a, 1);
    chk("youngest.opa", ex_opa, 32'h0000_00AA);
    // invalid slot, then a reader whose only producer sits in WB
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd12, 1, 0);
    tick();
    @(negedge cpu_clk);
    chk("wb_only.sel_a", ex_fwd_sel_a, 0);
    chk("wb_only.opa", ex_opa, 32'h0000_1111);
    // lw x13 then add x14,x13,x0 with a taken branch in EX
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1);
    tick();
    set_id(1, 5'd13, 1, 5'd0, 1, 5'd14, 1, 0);
    ex_br_taken = 1'b1;
    @(negedge cpu_clk);
    ctrl("flush", 0, 1, 1);
    tick();
    ex_br_taken = 1'b0;
    // add x15,x14,x13 : x14 was squashed, x13 load is now in MEM
    set_id(1, 5'd14, 1, 5'd13, 1, 5'd15, 1, 0);
    @(negedge cpu_clk);
    ctrl("post_flush", 0, 0, 0);
    chk("flush.flush_cnt", flush_cnt, 1);
    chk("flush.stall_cnt", stall_cnt, 1);
    chk("flush.bubble_sel_a", ex_fwd_sel_a, 0);
    tick();
    @(negedge cpu_clk);
    chk("post_flush.sel_a", ex_fwd_sel_a, 0);
    chk("post_flush.sel_b", ex_fwd_sel_b, 2);
    // reset during a load-use stall
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd16, 1, 1);
    tick();
    set_id(1, 5'd16, 1, 5'd0, 0, 5'd17, 1, 0);
    @(negedge cpu_clk);
    ctrl("pre_rst_stall", 1, 1, 0);
    cpu_rst = 1'b0;
    tick();
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    ctrl("rst_mid_stall", 0, 0, 0);
    chk("rst_mid_stall.stall_cnt", stall_cnt, 0);
    chk("rst_mid_stall.flush_cnt", flush_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
